// File: rtl/prog_mem_loader_if.sv
// rtl/prog_mem_loader_if.sv - fetch port and host load stream of the program memory
//
// Purpose: bundles the datapath fetch port (Pc/MemData/CpuRun) and the host
// program-load stream (LoadStart/InData/InValid/InLast/InReady/LoadCount).
// Ports (via modports):
//   slave  - the program memory (prog_mem_loader): drives MemData, CpuRun,
//            InReady, LoadCount; receives Pc, LoadStart, InData, InValid, InLast.
//   master - the datapath/host side: the reverse directions.
interface prog_mem_loader_if #(
    parameter int n    = 8,
    parameter int pc_n = 5
);
    logic [pc_n-1:0] Pc;
    logic [n-1:0]    MemData;
    logic            CpuRun;
    logic            LoadStart;
    logic [n-1:0]    InData;
    logic            InValid;
    logic            InLast;
    logic            InReady;
    logic [pc_n:0]   LoadCount;

    modport slave (
        input  Pc,
        input  LoadStart,
        input  InData,
        input  InValid,
        input  InLast,
        output MemData,
        output CpuRun,
        output InReady,
        output LoadCount
    );

    modport master (
        output Pc,
        output LoadStart,
        output InData,
        output InValid,
        output InLast,
        input  MemData,
        input  CpuRun,
        input  InReady,
        input  LoadCount
    );
endinterface

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - program memory with host stream loader and CPU run gate
//
// Purpose: 2**pc_n x n program memory for the accumulator CPU. A host streams
// program words in over a valid/ready handshake; the CPU is held off (CpuRun=0)
// until the load completes, so it never fetches from a half-written memory.
// Ports:
//   Clock  - system clock, rising edge
//   nReset - asynchronous active-low reset (memory contents are retained)
//   bus    - prog_mem_loader_if slave modport:
//            Pc/MemData  combinational fetch port, MemData forced to 0 unless CpuRun
//            CpuRun      1 while in RUN
//            LoadStart   pulse starting a new load (from IDLE or RUN)
//            InData/InValid/InLast/InReady  load stream, 1 word per cycle max
//            LoadCount   words written in the current/most recent load
module prog_mem_loader #(
    parameter int n    = 8,
    parameter int pc_n = 5
) (
    input  logic               Clock,
    input  logic               nReset,
    prog_mem_loader_if.slave   bus
);

    localparam int DEPTH = 2 ** pc_n;
    localparam logic [pc_n-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [pc_n-1:0] addr_q, addr_d;
    logic [pc_n:0]   count_q, count_d;
    logic            wr_en;

    logic [n-1:0]    mem_q [DEPTH];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.LoadStart) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                // LoadStart is deliberately not looked at here: a transfer always
                // wins, and an empty load simply waits for data.
                if (bus.InValid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (bus.InLast || addr_q == ADDR_LAST) begin
                        // Memory full also ends the load; hold the address
                        // instead of letting it wrap back to 0.
                        state_d = ST_RUN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.LoadStart) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // No reset on the array: a reset during a load keeps the words already written.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_q[addr_q] <= bus.InData;
        end
    end

    assign bus.InReady   = (state_q == ST_LOAD);
    assign bus.CpuRun    = (state_q == ST_RUN);
    assign bus.LoadCount = count_q;
    // Combinational fetch for the single-cycle datapath; a same-cycle write to
    // the same address shows up only after the edge, so reads see the old word.
    assign bus.MemData   = (state_q == ST_RUN) ? mem_q[bus.Pc] : '0;

endmodule
